// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: memory-mapped 8N1 UART receiver with a small byte FIFO and
// sticky overrun / framing-error flags, on the tri-state MDATA/MWAIT bus.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line idle, waiting for rx_s to go low
// S_START | half-bit wait, then confirm the start bit is still low
// S_DATA  | sample 8 data bits LSB-first, one per bit period
// S_STOP  | sample stop bit; high pushes the byte, low flags framing error
// S_BREAK | line held low after a bad stop bit, wait for it to go high
module uart_rx_mmio #(
  parameter int unsigned CLK        = 150000000,
  parameter int unsigned BAUD       = 3686400,
  parameter int unsigned BIT_CYC    = CLK / BAUD,
  parameter int unsigned HALF       = BIT_CYC / 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] BASE       = 32'h0000_0040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MADDR,
  inout  wire  [31:0] MDATA,
  input  logic        MEN,
  input  logic        MRW,
  output wire         MWAIT,
  input  logic        rx
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TMR_W = $clog2(BIT_CYC + 1);
  localparam logic [TMR_W-1:0] HALF_TC = TMR_W'(HALF - 1);
  localparam logic [TMR_W-1:0] BIT_TC  = TMR_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t             state_q, state_d;
  logic               sync_q, rx_s;
  logic [TMR_W-1:0]   tmr_q, tmr_val;
  logic               tmr_load, tmr_tc;
  logic [2:0]         bit_q;
  logic               bit_clr, shift_en;
  logic [7:0]         shreg;
  logic               push_req, ferr_set;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               full, empty, do_push, pop, ovr_set;
  logic               overrun, frame_err;

  logic               hit, rd, wr, clr_ovr, clr_ferr;
  logic [1:0]         off;
  logic [2:0]         count3;
  logic [31:0]        rdata;
  logic               unused_bits;

  // Two-flop synchronizer; both stages reset to the idle (high) level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_q <= rx;
      rx_s   <= sync_q;
    end
  end

  // The bit timer is a down-counter reloaded on every state entry and per data bit.
  assign tmr_tc = (tmr_q == '0);

  // Next-state and control strobes for the receive FSM.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = BIT_TC;
    bit_clr  = 1'b0;
    shift_en = 1'b0;
    push_req = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d  = S_START;
          tmr_load = 1'b1;
          tmr_val  = HALF_TC;
        end
      end
      S_START: begin
        if (tmr_tc) begin
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d  = S_DATA;
            tmr_load = 1'b1;
            bit_clr  = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tmr_tc) begin
          shift_en = 1'b1;
          tmr_load = 1'b1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tmr_tc) begin
          if (rx_s) begin
            push_req = 1'b1;
            state_d  = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, bit timer, bit index and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      shreg   <= '0;
    end else begin
      state_q <= state_d;
      if (tmr_load) tmr_q <= tmr_val;
      else if (!tmr_tc) tmr_q <= tmr_q - 1'b1;
      if (bit_clr) bit_q <= '0;
      else if (shift_en) bit_q <= bit_q + 1'b1;
      if (shift_en) shreg <= {rx_s, shreg[7:1]};
    end
  end

  assign hit      = MEN && (MADDR[31:4] == BASE[31:4]);
  assign off      = MADDR[3:2];
  assign rd       = hit && !MRW;
  assign wr       = hit && MRW;
  assign clr_ovr  = wr && (off == 2'd0) && MDATA[2];
  assign clr_ferr = wr && (off == 2'd0) && MDATA[3];

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign pop     = rd && (off == 2'd1) && !empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_req && (!full || pop);
  assign ovr_set = push_req && full && !pop;

  // FIFO storage; only written when a slot is available.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags; a set on the same edge as a W1C clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovr_set) overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
      if (ferr_set) frame_err <= 1'b1;
      else if (clr_ferr) frame_err <= 1'b0;
    end
  end

  assign count3 = 3'(count_q);

  // Register read mux; DATA returns the FIFO head combinationally, 0 when empty.
  always_comb begin
    rdata = '0;
    case (off)
      2'd0:    rdata = {25'd0, count3, frame_err, overrun, full, !empty};
      2'd1:    if (!empty) rdata = {24'd0, mem[rd_ptr]};
      default: rdata = '0;
    endcase
  end

  assign MDATA = rd ? rdata : 32'hzzzz_zzzz;
  assign MWAIT = hit ? 1'b0 : 1'bz;

  assign unused_bits = ^{MADDR[1:0], MDATA[31:4], MDATA[1:0]};

endmodule
